dice_seg_reader: RTL and testbench

DICE_SEG_READER -- requirements
Module: dice_seg_reader

---
 rtl/dice_seg_reader.sv | 157 +++++++++++++++
 tb/tb_dice_seg_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_seg_reader.sv
// Debounced seven-segment die reader: qualifies a stable segment pattern,
// reports the decoded face once per roll and keeps saturating roll statistics.
module dice_seg_reader #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       seg_i,
  input  logic             clr_i,
  input  logic [2:0]       sel_i,
  output logic [2:0]       face_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [CNT_W-1:0] hits_o
);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SETTLE,
    ST_HELD
  } state_e;

  localparam logic [7:0]       LAST_CNT = 8'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;

  logic       seg_blank;
  logic       seg_same;
  logic       report;
  logic [2:0] dec_face;
  logic       dec_legal;
  logic [7:0] inc;

  logic [2:0]       face_q;
  logic             valid_q;
  logic             err_q;
  // Index matches sel_i: 0 = TOTAL, 1..6 = per-face hits, 7 = error count.
  logic [CNT_W-1:0] stat_q [8];

  assign seg_blank = (seg_i == 7'b0000000);
  assign seg_same  = (seg_i == cand_q);
  assign report    = (state_q == ST_SETTLE) && !seg_blank && seg_same && (cnt_q == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_BLANK;
      cand_q  <= 7'b0000000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_BLANK: begin
        if (!seg_blank) begin
          cand_d  = seg_i;
          cnt_d   = 8'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (seg_blank) begin
          cnt_d   = 8'd0;
          state_d = ST_BLANK;
        end else if (!seg_same) begin
          cand_d = seg_i;
          cnt_d  = 8'd1;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HELD: begin
        if (seg_blank) begin
          state_d = ST_BLANK;
        end else if (!seg_same) begin
          cand_d  = seg_i;
          cnt_d   = 8'd1;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    dec_face  = 3'd0;
    dec_legal = 1'b1;
    unique case (seg_i)
      7'b0000110: dec_face = 3'd1;
      7'b1011011: dec_face = 3'd2;
      7'b1001111: dec_face = 3'd3;
      7'b1100110: dec_face = 3'd4;
      7'b1101101: dec_face = 3'd5;
      7'b1111101: dec_face = 3'd6;
      default:    dec_legal = 1'b0;
    endcase

    inc = 8'd0;
    if (report && dec_legal) begin
      inc[0]        = 1'b1;
      inc[dec_face] = 1'b1;
    end
    if (report && !dec_legal) begin
      inc[7] = 1'b1;
    end

    hits_o = stat_q[sel_i];
  end

  // NOTE: the statistics array is reset explicitly because its contents are
  // architecturally visible straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      face_q  <= 3'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      valid_q <= report && dec_legal;
      err_q   <= report && !dec_legal;
      if (report && dec_legal) begin
        face_q <= dec_face;
      end
      for (int i = 0; i < 8; i++) begin
        if (clr_i) begin
          stat_q[i] <= '0;
        end else if (inc[i] && (stat_q[i] != CNT_MAX)) begin
          stat_q[i] <= stat_q[i] + 1'b1;
        end
      end
    end
  end

  assign face_o  = face_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dice_seg_reader.sv
// Self-checking bench for dice_seg_reader: directed vector table, hand-written
// reset/saturation sequences and a randomized run against a run-length model.
`timescale 1ns/100ps
module tb_dice_seg_reader;

  localparam int STABLE_CYC = 4;
  localparam int CNT_W      = 8;
  localparam int SAT        = (1 << CNT_W) - 1;

  localparam logic [6:0] P0  = 7'b0000000;
  localparam logic [6:0] P1  = 7'b0000110;
  localparam logic [6:0] P2  = 7'b1011011;
  localparam logic [6:0] P3  = 7'b1001111;
  localparam logic [6:0] P4  = 7'b1100110;
  localparam logic [6:0] P5  = 7'b1101101;
  localparam logic [6:0] P6  = 7'b1111101;
  localparam logic [6:0] ILL = 7'b1111111;

  logic             clk_i;
  logic             rst_i;
  logic [6:0]       seg_i;
  logic             clr_i;
  logic [2:0]       sel_i;
  logic [2:0]       face_o;
  logic             valid_o;
  logic             err_o;
  logic [CNT_W-1:0] hits_o;

  dice_seg_reader #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .seg_i  (seg_i),
    .clr_i  (clr_i),
    .sel_i  (sel_i),
    .face_o (face_o),
    .valid_o(valid_o),
    .err_o  (err_o),
    .hits_o (hits_o)
  );

  always #10 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: length of the current run of identical non-blank samples.
  int         m_run;
  logic [6:0] m_last;
  int         m_face;
  bit         m_valid;
  bit         m_err;
  int         m_cnt [8];

  typedef struct {
    logic [6:0] seg;
    logic       clr;
    logic [2:0] sel;
    logic       ev;
    logic       ee;
    int         ef;
    int         eh;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dec(input logic [6:0] s);
    case (s)
      P0:      return 0;
      P1:      return 1;
      P2:      return 2;
      P3:      return 3;
      P4:      return 4;
      P5:      return 5;
      P6:      return 6;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_last = P0; m_face = 0; m_valid = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] < SAT) m_cnt[i]++;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic clr);
    int d;
    bit rep;
    d = dec(s);
    m_valid = 0;
    m_err   = 0;
    if (s == P0) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && s == m_last) m_run++;
      else m_run = 1;
      m_last = s;
    end
    rep = (m_run == STABLE_CYC);
    if (rep) begin
      if (d == 7) m_err = 1;
      else begin m_valid = 1; m_face = d; end
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else if (rep) begin
      if (d != 7) bump(0);
      bump(d);
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic clr);
    seg_i = seg;
    clr_i = clr;
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_edge(seg, clr);
    #1;
  endtask

  task automatic check_hits_const(input string tag, input int exp);
    for (int s = 0; s < 8; s++) begin
      sel_i = 3'(s);
      #1;
      check($sformatf("%s_sel%0d", tag, s), int'(hits_o), exp);
    end
  endtask

  task automatic add(input logic [6:0] seg, input logic clr, input logic [2:0] sel,
                     input logic ev, input logic ee, input int ef, input int eh);
    vec_t v;
    v.seg = seg; v.clr = clr; v.sel = sel; v.ev = ev; v.ee = ee; v.ef = ef; v.eh = eh;
    tbl.push_back(v);
  endtask

  initial begin
    logic [6:0] cur;
    clk_i = 0; rst_i = 1; seg_i = P0; clr_i = 0; sel_i = 0;
    model_reset();

    // Reset state, observed before any clock edge.
    #5;
    check("rst_face", int'(face_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_err", int'(err_o), 0);
    check_hits_const("rst_hits", 0);
    @(negedge clk_i);
    rst_i = 0;

    // Directed vectors: expected outputs after each edge.
    add(P2, 0, 2, 0, 0, 0, 0);
    add(P2, 0, 2, 0, 0, 0, 0);
    add(P2, 0, 0, 0, 0, 0, 0);
    add(P2, 0, 2, 1, 0, 2, 1);
    add(P2, 0, 0, 0, 0, 2, 1);
    add(P0, 0, 2, 0, 0, 2, 1);
    add(P4, 0, 4, 0, 0, 2, 0);
    add(P4, 0, 4, 0, 0, 2, 0);
    add(P4, 0, 4, 0, 0, 2, 0);
    add(P0, 0, 0, 0, 0, 2, 1);
    add(P0, 1, 2, 0, 0, 2, 0);
    add(ILL, 0, 7, 0, 0, 2, 0);
    add(ILL, 0, 7, 0, 0, 2, 0);
    add(ILL, 0, 7, 0, 0, 2, 0);
    add(ILL, 0, 7, 0, 1, 2, 1);
    add(ILL, 0, 0, 0, 0, 2, 0);
    add(P0, 0, 7, 0, 0, 2, 1);
    add(P3, 0, 3, 0, 0, 2, 0);
    add(P3, 0, 3, 0, 0, 2, 0);
    add(P3, 0, 3, 0, 0, 2, 0);
    add(P3, 1, 3, 1, 0, 3, 0);
    add(P3, 0, 0, 0, 0, 3, 0);
    add(P1, 0, 1, 0, 0, 3, 0);
    add(P1, 0, 1, 0, 0, 3, 0);
    add(P1, 0, 1, 0, 0, 3, 0);
    add(P1, 0, 1, 1, 0, 1, 1);
    add(P0, 0, 0, 0, 0, 1, 1);
    add(P4, 0, 4, 0, 0, 1, 0);
    add(P4, 0, 4, 0, 0, 1, 0);
    add(P5, 0, 5, 0, 0, 1, 0);
    add(P5, 0, 5, 0, 0, 1, 0);
    add(P5, 0, 5, 0, 0, 1, 0);
    add(P5, 0, 5, 1, 0, 5, 1);
    add(P0, 0, 0, 0, 0, 5, 2);

    foreach (tbl[i]) begin
      sel_i = tbl[i].sel;
      step(tbl[i].seg, tbl[i].clr);
      check($sformatf("vec%0d_valid", i), int'(valid_o), int'(tbl[i].ev));
      check($sformatf("vec%0d_err", i), int'(err_o), int'(tbl[i].ee));
      check($sformatf("vec%0d_face", i), int'(face_o), tbl[i].ef);
      check($sformatf("vec%0d_hits", i), int'(hits_o), tbl[i].eh);
    end

    // Saturation: 260 blank-separated rolls of face 6.
    step(P0, 1);
    for (int r = 0; r < 260; r++) begin
      for (int k = 0; k < STABLE_CYC; k++) step(P6, 0);
      step(P0, 0);
    end
    sel_i = 6; #1;
    check("sat_hit6", int'(hits_o), SAT);
    sel_i = 0; #1;
    check("sat_total", int'(hits_o), SAT);
    sel_i = 1; #1;
    check("sat_hit1", int'(hits_o), 0);
    check("sat_face", int'(face_o), 6);

    // Reset asserted mid-qualification, between clock edges.
    step(P5, 0);
    step(P5, 0);
    #3;
    rst_i = 1;
    #1;
    check("mid_rst_face", int'(face_o), 0);
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_err", int'(err_o), 0);
    check_hits_const("mid_rst_hits", 0);
    step(P5, 0);
    check("mid_rst_held_face", int'(face_o), 0);
    #2;
    rst_i = 0;
    for (int k = 1; k <= STABLE_CYC; k++) begin
      step(P5, 0);
      check($sformatf("requal%0d_valid", k), int'(valid_o), (k == STABLE_CYC) ? 1 : 0);
      check($sformatf("requal%0d_face", k), int'(face_o), (k == STABLE_CYC) ? 5 : 0);
    end

    // Randomized stimulus against the run-length model.
    cur = P0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) >= 70) begin
        case ($urandom_range(8))
          0:       cur = P0;
          1:       cur = P1;
          2:       cur = P2;
          3:       cur = P3;
          4:       cur = P4;
          5:       cur = P5;
          6:       cur = P6;
          default: cur = 7'($urandom_range(127));
        endcase
      end
      sel_i = 3'($urandom_range(7));
      step(cur, ($urandom_range(39) == 0) ? 1'b1 : 1'b0);
      check($sformatf("rnd%0d_valid", c), int'(valid_o), int'(m_valid));
      check($sformatf("rnd%0d_err", c), int'(err_o), int'(m_err));
      check($sformatf("rnd%0d_face", c), int'(face_o), m_face);
      check($sformatf("rnd%0d_hits", c), int'(hits_o), m_cnt[sel_i]);
      check($sformatf("rnd%0d_excl", c), int'(valid_o & err_o), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
